// File: rtl/full_adder_using_mux.sv
// WIDTH-bit ripple adder built only from 2:1 muxes, sum/carry registered.
// Latency 1 cycle, loads every cycle, no backpressure; async active-high reset clears outputs.

module full_adder_using_mux_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module full_adder_using_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             C
);
    logic [WIDTH-1:0] sum;
    logic             cout;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            logic ci, ci_n, co;
            logic s_lo, s_hi, c_lo, c_hi;

            // Each cell keeps its own carry nets so the chain is not one self-referencing vector.
            if (i == 0) begin : g_first
                assign ci = Cin;
            end else begin : g_rest
                assign ci = g_cell[i-1].co;
            end

            assign ci_n = ~ci;

            // Sum: data (ci, ~ci, ~ci, ci) for {A,B} = 00,01,10,11.
            full_adder_using_mux_mux2 u_s_lo (.d0(ci),   .d1(ci_n), .sel(B[i]), .y(s_lo));
            full_adder_using_mux_mux2 u_s_hi (.d0(ci_n), .d1(ci),   .sel(B[i]), .y(s_hi));
            full_adder_using_mux_mux2 u_s    (.d0(s_lo), .d1(s_hi), .sel(A[i]), .y(sum[i]));

            // Carry: data (0, ci, ci, 1) for {A,B} = 00,01,10,11.
            full_adder_using_mux_mux2 u_c_lo (.d0(1'b0), .d1(ci),   .sel(B[i]), .y(c_lo));
            full_adder_using_mux_mux2 u_c_hi (.d0(ci),   .d1(1'b1), .sel(B[i]), .y(c_hi));
            full_adder_using_mux_mux2 u_c    (.d0(c_lo), .d1(c_hi), .sel(A[i]), .y(co));
        end
    endgenerate

    assign cout = g_cell[WIDTH-1].co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S <= '0;
            C <= 1'b0;
        end else begin
            S <= sum;
            C <= cout;
        end
    end
endmodule

// File: tb/tb_full_adder_using_mux.sv
// Bench for full_adder_using_mux: WIDTH=1 and WIDTH=8 instances against an arithmetic model.

module tb_full_adder_using_mux;
    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, cin1, s1, c1;
    logic [7:0] a8, b8, s8;
    logic       cin8, c8;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    full_adder_using_mux #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .S(s1), .C(c1)
    );

    full_adder_using_mux #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .S(s8), .C(c8)
    );

    function automatic logic [1:0] model1(input logic a, input logic b, input logic ci);
        return 2'(a) + 2'(b) + 2'(ci);
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        return 9'(a) + 9'(b) + 9'(ci);
    endfunction

    task automatic test_reset();
        #2;
        tests++;
        if ({c1, s1} !== 2'b00) begin
            fails++;
            $display("FAIL reset_w1: got %b want 00", {c1, s1});
        end
        tests++;
        if ({c8, s8} !== 9'h000) begin
            fails++;
            $display("FAIL reset_w8: got %h want 000", {c8, s8});
        end
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({c1, s1, c8, s8} !== 11'h000) begin
            fails++;
            $display("FAIL reset_hold: got w1=%b w8=%h want all zero", {c1, s1}, {c8, s8});
        end
        #3 rst = 1'b0;
    endtask

    task automatic test_exhaustive_w1();
        logic [2:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            {a1, b1, cin1} = v;
            @(posedge clk); #1;
            tests++;
            if ({c1, s1} !== model1(v[2], v[1], v[0])) begin
                fails++;
                $display("FAIL exhaustive_w1 abc=%b: got %b want %b", v, {c1, s1}, model1(v[2], v[1], v[0]));
            end
        end
    endtask

    task automatic test_hold_w1();
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({c1, s1} !== 2'b11) begin
                fails++;
                $display("FAIL hold_w1 cycle %0d: got %b want 11", k, {c1, s1});
            end
        end
    endtask

    task automatic test_async_reset();
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({c1, s1} !== 2'b00) begin
            fails++;
            $display("FAIL async_reset_w1: got %b want 00", {c1, s1});
        end
        tests++;
        if ({c8, s8} !== 9'h000) begin
            fails++;
            $display("FAIL async_reset_w8: got %h want 000", {c8, s8});
        end
        #1 rst = 1'b0;
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({c1, s1} !== 2'b01) begin
            fails++;
            $display("FAIL post_reset_w1: got %b want 01", {c1, s1});
        end
    endtask

    task automatic test_latency();
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk); #1;
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1;
        #3;
        tests++;
        if ({c1, s1} !== 2'b00) begin
            fails++;
            $display("FAIL latency_before_edge: got %b want 00", {c1, s1});
        end
        @(posedge clk); #1;
        tests++;
        if ({c1, s1} !== 2'b10) begin
            fails++;
            $display("FAIL latency_after_edge: got %b want 10", {c1, s1});
        end
    endtask

    task automatic test_directed_w8();
        logic [7:0] ta [4] = '{8'hFF, 8'h5A, 8'hFF, 8'h00};
        logic [7:0] tb [4] = '{8'h00, 8'h3C, 8'hFF, 8'h00};
        logic       tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [8:0] want [4] = '{9'h100, 9'h096, 9'h1FF, 9'h000};
        for (int k = 0; k < 4; k++) begin
            a8 = ta[k]; b8 = tb[k]; cin8 = tc[k];
            @(posedge clk); #1;
            tests++;
            if ({c8, s8} !== want[k]) begin
                fails++;
                $display("FAIL directed_w8 %h+%h+%b: got %h want %h", ta[k], tb[k], tc[k], {c8, s8}, want[k]);
            end
        end
    endtask

    task automatic test_random_w8();
        logic [8:0] prev;
        logic [8:0] exp_v;
        prev = model8(a8, b8, cin8);
        for (int k = 0; k < 1000; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom);
            exp_v = model8(a8, b8, cin8);
            #3;
            tests++;
            if ({c8, s8} !== prev) begin
                fails++;
                $display("FAIL random_w8_hold %0d: got %h want %h", k, {c8, s8}, prev);
            end
            @(posedge clk); #1;
            tests++;
            if ({c8, s8} !== exp_v) begin
                fails++;
                $display("FAIL random_w8 %0d %h+%h+%b: got %h want %h", k, a8, b8, cin8, {c8, s8}, exp_v);
            end
            prev = exp_v;
        end
    endtask

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        test_reset();
        test_exhaustive_w1();
        test_hold_w1();
        test_async_reset();
        test_latency();
        test_directed_w8();
        test_random_w8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
